// File: rtl/operand_fetch_pkg.sv
// Shared constants, opcodes and the ID/EX bundle for the operand stage.
// Optional build macro: FWD_EX_EN (EX-to-ID forwarding in operand_fetch).
package operand_fetch_pkg;

   localparam int DATA_W = 16;
   localparam int REG_N  = 8;
   localparam int ADDR_W = 3;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_PASSB = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB   = 3'd2;
   localparam logic [OP_W-1:0] OP_AND   = 3'd3;
   localparam logic [OP_W-1:0] OP_OR    = 3'd4;
   localparam logic [OP_W-1:0] OP_NOTB  = 3'd5;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] rd;
      logic              we;
      logic              valid;
   } id_ex_t;

   // Bubble: PASSB with B=0, no write-back, not valid.
   localparam id_ex_t ID_EX_BUBBLE = '{
      a: '0, b: '0, op: OP_PASSB, rd: '0, we: 1'b0, valid: 1'b0
   };

endpackage

// File: rtl/operand_fetch_reg_file.sv
// 8 x 16 register file: R0 hardwired to zero, combinational reads with
// write-back bypass on both read ports.
// Ports: clk, rst, wb_en/wb_addr/wb_data write, rs/rt addr in, rs/rt data out.
module operand_fetch_reg_file
   import operand_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data
);

   logic [DATA_W-1:0] r_mem [REG_N];

   // Entry 0 is cleared on reset and never written, reads force 0 anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         r_mem[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rs_data = r_mem[rs_addr];
      rt_data = r_mem[rt_addr];
      if (wb_en && (wb_addr == rs_addr)) rs_data = wb_data;
      if (wb_en && (wb_addr == rt_addr)) rt_data = wb_data;
      if (rs_addr == '0) rs_data = '0;
      if (rt_addr == '0) rt_data = '0;
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read, operand muxing and ID/EX register
// feeding the ALU. Define FWD_EX_EN to forward alu_w from EX into A/B.
// Ports: decoded instr (in_valid, rs/rt/rd, imm, op_in), stall/flush,
// write-back (wb_*), alu_w, registered ALU operands and EX control out.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] imm,
   input  logic              use_imm,
   input  logic [OP_W-1:0]   op_in,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_we,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] alu_w,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_we,
   output logic              out_valid
);

   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_rt_data;
   logic [DATA_W-1:0] w_a_val;
   logic [DATA_W-1:0] w_b_val;
   id_ex_t            r_idex;
   id_ex_t            w_load;

   operand_fetch_reg_file u_rf (
      .clk     (clk),
      .rst     (rst),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rs_addr (rs_addr),
      .rt_addr (rt_addr),
      .rs_data (w_rs_data),
      .rt_data (w_rt_data)
   );

`ifdef FWD_EX_EN
   logic w_ex_hit;
   assign w_ex_hit = r_idex.valid & r_idex.we & (r_idex.rd != '0);

   // EX result beats the write-back bypass already applied in reg_file.
   assign w_a_val = (w_ex_hit && (r_idex.rd == rs_addr)) ? alu_w : w_rs_data;
   assign w_b_val = (w_ex_hit && (r_idex.rd == rt_addr)) ? alu_w : w_rt_data;
`else
   logic w_unused_alu_w;
   assign w_unused_alu_w = ^alu_w;
   assign w_a_val = w_rs_data;
   assign w_b_val = w_rt_data;
`endif

   always_comb begin
      w_load = ID_EX_BUBBLE;
      if (in_valid) begin
         w_load.a     = w_a_val;
         w_load.b     = use_imm ? imm : w_b_val;
         w_load.op    = op_in;
         w_load.rd    = rd_addr;
         w_load.we    = rd_we;
         w_load.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) r_idex <= ID_EX_BUBBLE;
      else if (!stall)  r_idex <= w_load;
   end

   assign alu_a     = r_idex.a;
   assign alu_b     = r_idex.b;
   assign alu_op    = r_idex.op;
   assign ex_rd     = r_idex.rd;
   assign ex_we     = r_idex.we;
   assign out_valid = r_idex.valid;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then random traffic
// checked against a behavioural model of the register file and ID/EX stage.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] imm;
   logic              use_imm;
   logic [OP_W-1:0]   op_in;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_we;
   logic              stall;
   logic              flush;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] alu_w;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [ADDR_W-1:0] ex_rd;
   logic              ex_we;
   logic              out_valid;

   operand_fetch dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm),
      .use_imm(use_imm), .op_in(op_in), .rd_addr(rd_addr),
      .rd_we(rd_we), .stall(stall), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .alu_w(alu_w), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .ex_rd(ex_rd), .ex_we(ex_we),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned a, b, op, rd, we, v;
   } exp_t;

   exp_t        sb[$];
   int unsigned regs[8];
   exp_t        m;
   int          vectors = 0;
   int          errors  = 0;
   bit          done    = 0;

   // Operand read seen by an instruction in ID this cycle.
   function automatic int unsigned rd_model(input int unsigned a);
      if (a == 0) return 0;
`ifdef FWD_EX_EN
      if (m.v == 1 && m.we == 1 && m.rd == a) return alu_w;
`endif
      if (wb_en && wb_addr == a) return wb_data;
      return regs[a];
   endfunction

   // Predict the state after the coming edge and queue it.
   task automatic commit();
      exp_t n;
      exp_t bub = '{0, 0, 0, 0, 0, 0};
      n = m;
      if (rst || flush) n = bub;
      else if (!stall) begin
         if (!in_valid) n = bub;
         else begin
            n.a  = rd_model(rs_addr);
            n.b  = use_imm ? imm : rd_model(rt_addr);
            n.op = op_in;
            n.rd = rd_addr;
            n.we = rd_we;
            n.v  = 1;
         end
      end
      if (rst) foreach (regs[i]) regs[i] = 0;
      else if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
      m = n;
      sb.push_back(n);
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0;
      use_imm = 0; op_in = 0; rd_addr = 0; rd_we = 0; stall = 0;
      flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; alu_w = 0;
   endtask

   task automatic instr(input int rs, input int rt, input int op);
      in_valid = 1; rs_addr = rs[2:0]; rt_addr = rt[2:0];
      op_in = op[2:0];
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         vectors++;
         if (alu_a !== e.a[15:0] || alu_b !== e.b[15:0] ||
             alu_op !== e.op[2:0] || ex_rd !== e.rd[2:0] ||
             ex_we !== e.we[0] || out_valid !== e.v[0]) begin
            errors++;
            $display("FAIL vec%0d got a=%h b=%h op=%0d rd=%0d we=%b v=%b exp a=%h b=%h op=%0d rd=%0d we=%0d v=%0d",
               vectors, alu_a, alu_b, alu_op, ex_rd, ex_we, out_valid,
               e.a, e.b, e.op, e.rd, e.we, e.v);
         end
      end
   end

   initial begin
      m = '{0, 0, 0, 0, 0, 0};
      foreach (regs[i]) regs[i] = 0;
      @(negedge clk);
      idle(); rst = 1; commit();
      @(negedge clk); commit();
      // every register reads 0 after reset
      for (int i = 1; i < 8; i++) begin
         @(negedge clk); idle(); instr(i, i, 1); commit();
      end
      @(negedge clk); idle();
      wb_en = 1; wb_addr = 3; wb_data = 16'h1234; commit();
      @(negedge clk); idle(); instr(3, 0, 1); commit();
      @(negedge clk); idle(); instr(5, 5, 3);
      wb_en = 1; wb_addr = 5; wb_data = 16'hBEEF; commit();
      @(negedge clk); idle(); instr(0, 0, 4);
      wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; commit();
      @(negedge clk); idle(); instr(0, 0, 4); commit();
      @(negedge clk); idle(); instr(5, 3, 2);
      use_imm = 1; imm = 16'h8001; rd_addr = 4; rd_we = 1; commit();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); instr(i + 1, 3, i); stall = 1;
         imm = 16'($urandom); commit();
      end
      @(negedge clk); idle(); instr(3, 3, 1); stall = 1; flush = 1;
      commit();
      @(negedge clk); idle(); rd_we = 1; rd_addr = 6; commit();
      // EX forwarding vs write-back bypass on R2
      @(negedge clk); idle();
      wb_en = 1; wb_addr = 2; wb_data = 16'h0011; commit();
      @(negedge clk); idle(); instr(1, 1, 1);
      rd_addr = 2; rd_we = 1; commit();
      @(negedge clk); idle(); instr(2, 2, 1); alu_w = 16'h00AA;
      wb_en = 1; wb_addr = 2; wb_data = 16'h0022; commit();
      @(negedge clk); idle(); commit();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 99) < 3);
         in_valid = ($urandom_range(0, 99) < 80);
         rs_addr  = 3'($urandom);
         rt_addr  = 3'($urandom);
         imm      = 16'($urandom);
         use_imm  = 1'($urandom);
         op_in    = 3'($urandom_range(0, 5));
         rd_addr  = 3'($urandom);
         rd_we    = 1'($urandom);
         stall    = ($urandom_range(0, 99) < 20);
         flush    = ($urandom_range(0, 99) < 10);
         wb_en    = 1'($urandom);
         wb_addr  = 3'($urandom);
         wb_data  = 16'($urandom);
         alu_w    = 16'($urandom);
         commit();
      end
      @(negedge clk); idle(); commit();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
